// File: rtl/arc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arc4_pkg
//  Purpose  : Shared constants and types for the ARC4 sequencer slice:
//             sequencer state encodings, S-memory phase/owner encodings,
//             S-memory geometry and the default key width.
//  Revision : 1.0  initial release
// ============================================================================
package arc4_pkg;

  localparam int S_DEPTH       = 256;
  localparam int S_AW          = $clog2(S_DEPTH);
  localparam int KEY_W_DEFAULT = 24;

  // Sequencer states, plain constants so older tools can consume them too.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_START_INIT = 3'd1;
  localparam state_t ST_WAIT_INIT  = 3'd2;
  localparam state_t ST_START_KSA  = 3'd3;
  localparam state_t ST_WAIT_KSA   = 3'd4;
  localparam state_t ST_START_PRGA = 3'd5;
  localparam state_t ST_WAIT_PRGA  = 3'd6;
  localparam state_t ST_DONE       = 3'd7;

  // Phase doubles as the S-memory owner select and the LED status code.
  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_INIT = 2'd1,
    PH_KSA  = 2'd2,
    PH_PRGA = 2'd3
  } phase_e;

  function automatic phase_e state_to_phase(input state_t s);
    phase_e p;
    case (s)
      ST_START_INIT, ST_WAIT_INIT: p = PH_INIT;
      ST_START_KSA,  ST_WAIT_KSA:  p = PH_KSA;
      ST_START_PRGA, ST_WAIT_PRGA: p = PH_PRGA;
      default:                     p = PH_IDLE;
    endcase
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arc4_smem_mux.sv
`default_nettype none
// ============================================================================
//  Module   : arc4_smem_mux
//  Purpose  : Combinational 3:1 selector for the single S-memory port. The
//             engine named by phase drives the port; every other engine,
//             including its write enable, is blocked. PH_IDLE parks the
//             port at address 0 with no write.
//  Ports    : phase                  owner select (arc4_pkg::phase_e)
//             init_/ksa_/prga_addr   engine address requests
//             init_/ksa_/prga_wrdata engine write data
//             init_/ksa_/prga_wren   engine write enables
//             s_addr/s_wrdata/s_wren selected port toward S memory
//  Revision : 1.0  initial release
// ============================================================================
module arc4_smem_mux
  import arc4_pkg::*;
(
  input  phase_e          phase,
  input  logic [S_AW-1:0] init_addr,
  input  logic [7:0]      init_wrdata,
  input  logic            init_wren,
  input  logic [S_AW-1:0] ksa_addr,
  input  logic [7:0]      ksa_wrdata,
  input  logic            ksa_wren,
  input  logic [S_AW-1:0] prga_addr,
  input  logic [7:0]      prga_wrdata,
  input  logic            prga_wren,
  output logic [S_AW-1:0] s_addr,
  output logic [7:0]      s_wrdata,
  output logic            s_wren
);

  always_comb begin
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    case (phase)
      PH_INIT: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
      end
      PH_KSA: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
      end
      PH_PRGA: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/arc4_seq.sv
`default_nettype none
// ============================================================================
//  Module   : arc4_seq
//  Purpose  : Top-level ARC4 sequencer. One accepted start runs the init,
//             ksa and prga engines in order through their en/rdy handshakes
//             and grants the single S-memory port to the active engine.
//  Ports    : clk, rst              clock, synchronous active-high reset
//             en/rdy, key           job request handshake and key
//             key_q                 key captured on the accepted request
//             *_en / *_rdy          engine start pulses and ready flags
//             *_addr/_wrdata/_wren  engine S-memory requests
//             s_addr/s_wrdata/s_wren granted S-memory port
//             phase                 0 idle, 1 init, 2 ksa, 3 prga
//             err                   per-phase watchdog tripped
//  Config   : `define ARC4_SEQ_TIMEOUT_EN adds a per-phase watchdog of
//             TIMEOUT_CYCLES cycles; without it err is tied low and the
//             wait states wait indefinitely.
//  Revision : 1.0  initial release
// ============================================================================
module arc4_seq
  import arc4_pkg::*;
#(
  parameter int KEY_W          = KEY_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             rdy,
  input  logic [KEY_W-1:0] key,
  output logic [KEY_W-1:0] key_q,
  output logic             init_en,
  output logic             ksa_en,
  output logic             prga_en,
  input  logic             init_rdy,
  input  logic             ksa_rdy,
  input  logic             prga_rdy,
  input  logic [7:0]       init_addr,
  input  logic [7:0]       ksa_addr,
  input  logic [7:0]       prga_addr,
  input  logic [7:0]       init_wrdata,
  input  logic [7:0]       ksa_wrdata,
  input  logic [7:0]       prga_wrdata,
  input  logic             init_wren,
  input  logic             ksa_wren,
  input  logic             prga_wren,
  output logic [7:0]       s_addr,
  output logic [7:0]       s_wrdata,
  output logic             s_wren,
  output logic [1:0]       phase,
  output logic             err
);

  // The watchdog counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range_check
    $error("arc4_seq: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t           state_q, state_d;
  logic             seen_busy_q, seen_busy_d;
  logic [KEY_W-1:0] key_d;
  logic             in_wait;
  phase_e           owner;
  logic             mux_wren;

  assign rdy     = (state_q == ST_IDLE);
  assign owner   = state_to_phase(state_q);
  assign phase   = owner;
  assign in_wait = (state_q == ST_WAIT_INIT) || (state_q == ST_WAIT_KSA) ||
                   (state_q == ST_WAIT_PRGA);

`ifdef ARC4_SEQ_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    seen_busy_d = seen_busy_q;
    key_d       = key_q;
    init_en     = 1'b0;
    ksa_en      = 1'b0;
    prga_en     = 1'b0;

    // Each START state fires its engine only once the engine is ready, and
    // clears seen_busy so the engine's stale rdy after the pulse cannot end
    // the WAIT state; the engine must drop rdy and raise it again first.
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          key_d   = key;
          state_d = ST_START_INIT;
        end
      end
      ST_START_INIT: begin
        if (init_rdy) begin
          init_en     = 1'b1;
          seen_busy_d = 1'b0;
          state_d     = ST_WAIT_INIT;
        end
      end
      ST_WAIT_INIT: begin
        if (!init_rdy)        seen_busy_d = 1'b1;
        else if (seen_busy_q) state_d     = ST_START_KSA;
      end
      ST_START_KSA: begin
        if (ksa_rdy) begin
          ksa_en      = 1'b1;
          seen_busy_d = 1'b0;
          state_d     = ST_WAIT_KSA;
        end
      end
      ST_WAIT_KSA: begin
        if (!ksa_rdy)         seen_busy_d = 1'b1;
        else if (seen_busy_q) state_d     = ST_START_PRGA;
      end
      ST_START_PRGA: begin
        if (prga_rdy) begin
          prga_en     = 1'b1;
          seen_busy_d = 1'b0;
          state_d     = ST_WAIT_PRGA;
        end
      end
      ST_WAIT_PRGA: begin
        if (!prga_rdy)        seen_busy_d = 1'b1;
        else if (seen_busy_q) state_d     = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

`ifdef ARC4_SEQ_TIMEOUT_EN
    to_cnt_d = '0;
    err_d    = err_q;
    if (in_wait) begin
      to_cnt_d = to_cnt_q + 16'd1;
      // A normal phase exit on the same cycle wins over the watchdog.
      if (to_cnt_d == TIMEOUT_LIM && state_d == state_q) begin
        state_d = ST_DONE;
        err_d   = 1'b1;
      end
    end
    if (state_q == ST_IDLE && en) err_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      seen_busy_q <= 1'b0;
      key_q       <= '0;
    end else begin
      state_q     <= state_d;
      seen_busy_q <= seen_busy_d;
      key_q       <= key_d;
    end
  end

`ifdef ARC4_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end
`endif

  arc4_smem_mux u_smem_mux (
    .phase       (owner),
    .init_addr   (init_addr),
    .init_wrdata (init_wrdata),
    .init_wren   (init_wren),
    .ksa_addr    (ksa_addr),
    .ksa_wrdata  (ksa_wrdata),
    .ksa_wren    (ksa_wren),
    .prga_addr   (prga_addr),
    .prga_wrdata (prga_wrdata),
    .prga_wren   (prga_wren),
    .s_addr      (s_addr),
    .s_wrdata    (s_wrdata),
    .s_wren      (mux_wren)
  );

  // Reset blocks memory writes in the same cycle, before the state clears.
  assign s_wren = mux_wren & ~rst;

  // in_wait only feeds the watchdog; keep it referenced in every build.
  logic unused_in_wait;
  assign unused_in_wait = in_wait;

endmodule
`default_nettype wire
